// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame packer: sync bytes, FSM encoding
// and FIFO entry width.
package uart_pkg;

  localparam logic [7:0] SYNC0   = 8'hA5;
  localparam logic [7:0] SYNC1   = 8'h5A;
  localparam int         ENTRY_W = 9;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SEND    = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4
  } state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous first-word-fall-through FIFO of {marker, byte} entries.
// The head entry is always visible on 'head' while the FIFO is non-empty.
// A push is refused whenever the FIFO is full, even if a pop happens in the
// same cycle, so the level never exceeds DEPTH.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic [ADDR_W:0]    level,
  output logic               full,
  output logic               empty
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]    level_q, level_d;
  logic               push_ok, pop_ok;

  assign full    = (level_q == FULL_LEVEL);
  assign empty   = (level_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign level   = level_q;
  // Fall-through read: the head must be usable in the cycle it is popped.
  assign head    = mem_q[rd_ptr_q];

  // Pointer and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
      2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage write; contents need no reset because pointers define validity.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointer/level registers; reset discards all queued entries.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/uart_frame_packer.sv
// UART frame packer: buffers pixel bytes, inserts an A5 5A <frame_no> header
// on each vsync rising edge and paces bytes into the UART transmitter using
// its busy flag. Optional macro UART_FRAME_CSUM_EN adds an XOR checksum of the
// previous frame's data bytes ahead of each header (except the first).
module uart_frame_packer
  import uart_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  input  logic              vsync,
  input  logic              tx_busy,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic [ADDR_W:0]   fifo_level,
  output logic              overflow,
  output logic [7:0]        frame_count
);

  state_e             state_q, state_d;
  logic               vsync_prev_q, vsync_prev_d;
  logic [7:0]         frame_count_q, frame_count_d;
  logic               overflow_q, overflow_d;
  logic [ENTRY_W-1:0] entry_q, entry_d;
  logic [1:0]         idx_q, idx_d;
  logic [7:0]         tx_data_q, tx_data_d;
`ifdef UART_FRAME_CSUM_EN
  logic [7:0]         csum_q, csum_d;
  logic               armed_q, armed_d;
`endif

  logic               vsync_edge;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_wdata, fifo_head;
  logic [7:0]         cur_byte;

  // A vsync edge wins the write port; a simultaneous pixel is lost.
  assign vsync_edge = vsync & ~vsync_prev_q;
  assign fifo_push  = vsync_edge | pix_valid;
  assign fifo_wdata = vsync_edge ? {1'b1, frame_count_q} : {1'b0, pix_data};

  uart_byte_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Write-side bookkeeping: edge history, frame numbering, sticky overflow.
  always_comb begin
    vsync_prev_d  = vsync;
    frame_count_d = frame_count_q + (vsync_edge ? 8'd1 : 8'd0);
    overflow_d    = overflow_q | (vsync_edge & pix_valid) | (fifo_push & fifo_full);
  end

  // Byte for the current position; markers walk csum, A5, 5A, frame_no.
  always_comb begin
    cur_byte = entry_q[7:0];
    if (entry_q[8]) begin
      case (idx_q)
`ifdef UART_FRAME_CSUM_EN
        2'd0:    cur_byte = csum_q;
`endif
        2'd1:    cur_byte = SYNC0;
        2'd2:    cur_byte = SYNC1;
        default: cur_byte = entry_q[7:0];
      endcase
    end
  end

  // Transmit FSM next-state and outputs.
  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    idx_d     = idx_q;
    tx_data_d = tx_data_q;
    fifo_pop  = 1'b0;
`ifdef UART_FRAME_CSUM_EN
    csum_d    = csum_q;
    armed_d   = armed_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !tx_busy) begin
          fifo_pop = 1'b1;
          entry_d  = fifo_head;
          idx_d    = 2'd1;
`ifdef UART_FRAME_CSUM_EN
          if (fifo_head[8]) begin
            // The very first marker has no preceding frame to summarise.
            if (armed_q) idx_d = 2'd0;
            else         csum_d = 8'h00;
            armed_d = 1'b1;
          end
`endif
          state_d = LOAD;
        end
      end
      LOAD: begin
        tx_data_d = cur_byte;
        state_d   = SEND;
      end
      SEND: begin
`ifdef UART_FRAME_CSUM_EN
        if (!entry_q[8])        csum_d = csum_q ^ entry_q[7:0];
        else if (idx_q == 2'd0) csum_d = 8'h00;
`endif
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (entry_q[8] && idx_q != 2'd3) begin
            idx_d   = idx_q + 2'd1;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any frame in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      vsync_prev_q  <= 1'b1;
      frame_count_q <= 8'h00;
      overflow_q    <= 1'b0;
      entry_q       <= '0;
      idx_q         <= 2'd0;
      tx_data_q     <= 8'h00;
`ifdef UART_FRAME_CSUM_EN
      csum_q        <= 8'h00;
      armed_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      vsync_prev_q  <= vsync_prev_d;
      frame_count_q <= frame_count_d;
      overflow_q    <= overflow_d;
      entry_q       <= entry_d;
      idx_q         <= idx_d;
      tx_data_q     <= tx_data_d;
`ifdef UART_FRAME_CSUM_EN
      csum_q        <= csum_d;
      armed_q       <= armed_d;
`endif
    end
  end

  // tx_valid is gated by reset so an abort drops the strobe immediately.
  assign tx_valid    = (state_q == SEND) & ~reset;
  assign tx_data     = tx_data_q;
  assign overflow    = overflow_q;
  assign frame_count = frame_count_q;

endmodule
